// File: rtl/rnd_backoff.sv
// rnd_backoff: Fibonacci LFSR random source with a random-interval backoff counter.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_shift      advance the LFSR one step
//   i_seed_load  load the LFSR from i_seed (zero seed loads all ones)
//   i_seed       seed value
//   i_start      request a backoff of R+1 busy cycles, R = o_out
//   i_abort      cancel a backoff in progress
//   o_out        R = low OUT_W bits of the LFSR
//   o_out_termo  thermometer code of o_out (bit k set iff k <= o_out)
//   o_state      full LFSR contents
//   o_busy       high while counting
//   o_done       one-cycle pulse when the count completes
module rnd_backoff #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(16'h002D),
    parameter int                 OUT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_shift,
    input  logic                  i_seed_load,
    input  logic [WIDTH-1:0]      i_seed,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic [OUT_W-1:0]      o_out,
    output logic [(1<<OUT_W)-1:0] o_out_termo,
    output logic [WIDTH-1:0]      o_state,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int TERMO_W = 1 << OUT_W;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state;
    logic [OUT_W-1:0] cnt;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] s_next;
    logic             fb;
    logic             start_ok;

    assign fb       = ^(s_reg & TAPS);
    assign start_ok = (state == IDLE) && i_start && !i_abort;
    assign o_out    = s_reg[OUT_W-1:0];
    assign o_state  = s_reg;

    // A zero register would lock the LFSR, so it is forced back to all ones
    // unless a nonzero seed is being loaded that same edge.
    always_comb
        s_next = i_seed_load          ? ((i_seed == '0) ? '1 : i_seed) :
                 (s_reg == '0)        ? '1 :
                 (i_shift || start_ok) ? {fb, s_reg[WIDTH-1:1]} : s_reg;

    for (genvar k = 0; k < TERMO_W; k++) begin : g_termo
        assign o_out_termo[k] = o_out >= OUT_W'(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg  <= '1;
            state  <= IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            s_reg <= s_next;
            case (state)
                IDLE: if (start_ok) begin
                    state  <= COUNT;
                    cnt    <= o_out;
                    o_busy <= 1'b1;
                end
                COUNT: if (i_abort) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_busy <= 1'b0;
                end else if (cnt == '0) begin
                    state  <= DONE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rnd_backoff.sv
// tb_rnd_backoff: self-checking bench for rnd_backoff with directed scenarios and a randomized reference-model run.
module tb_rnd_backoff;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_shift = 1'b0;
    logic        i_seed_load = 1'b0;
    logic [15:0] i_seed = '0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [2:0]  o_out;
    logic [7:0]  o_out_termo;
    logic [15:0] o_state;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int passed = 0;

    bit visited [0:65535];

    rnd_backoff dut (
        .clk(clk), .rst_n(rst_n), .i_shift(i_shift), .i_seed_load(i_seed_load),
        .i_seed(i_seed), .i_start(i_start), .i_abort(i_abort), .o_out(o_out),
        .o_out_termo(o_out_termo), .o_state(o_state), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Reference LFSR step: feedback is the parity of the tapped bits (0,2,3,5).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = ($countones(s & 16'h002D) % 2) == 1;
        return {fb, s[15:1]};
    endfunction

    function automatic logic [7:0] therm(input logic [2:0] r);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) t[k] = (k <= int'(r));
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_shift = 0; i_seed_load = 0; i_seed = '0; i_start = 0; i_abort = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (o_state !== 16'hFFFF || o_out !== 3'd7 || o_out_termo !== 8'hFF || o_busy !== 1'b0 || o_done !== 1'b0)
            $display("FAIL reset: state=%h out=%0d termo=%h busy=%b done=%b, want ffff 7 ff 0 0",
                     o_state, o_out, o_out_termo, o_busy, o_done);
        else passed++;
        tick();
        rst_n = 1;
    endtask

    task automatic test_shift();
        logic [15:0] exp_s [4];
        exp_s[0] = 16'hFFFF; exp_s[1] = 16'h7FFF; exp_s[2] = 16'h3FFF; exp_s[3] = 16'h1FFF;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_state !== exp_s[i] || o_out !== 3'd7)
                $display("FAIL shift%0d: state=%h out=%0d, want %h 7", i, o_state, o_out, exp_s[i]);
            else passed++;
            i_shift = 1;
            if (i < 3) tick();
        end
        idle_inputs();
    endtask

    task automatic test_seed();
        do_reset();
        i_shift = 1;
        tick();
        i_shift = 0;
        i_seed_load = 1; i_seed = 16'h0000;
        tick();
        checks++;
        if (o_state !== 16'hFFFF) $display("FAIL seed_zero: state=%h, want ffff", o_state);
        else passed++;
        i_seed = 16'hACE1; i_shift = 1;
        tick();
        checks++;
        if (o_state !== 16'hACE1) $display("FAIL seed_prio: state=%h, want ace1", o_state);
        else passed++;
        i_seed_load = 0;
        tick();
        i_shift = 0;
        checks++;
        if (o_state !== 16'h5670 || o_out !== 3'd0 || o_out_termo !== 8'h01)
            $display("FAIL seed_shift: state=%h out=%0d termo=%h, want 5670 0 01", o_state, o_out, o_out_termo);
        else passed++;
    endtask

    task automatic test_backoff();
        int busy_n = 0, done_n = 0, last_busy = -1, done_at = -1;
        do_reset();
        i_start = 1;
        tick();
        i_start = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_busy) begin busy_n++; last_busy = i; end
            if (o_done) begin done_n++; done_at = i; end
            i_start = (i == 1);
            tick();
        end
        i_start = 0;
        checks++;
        if (busy_n != 8 || done_n != 1 || done_at != last_busy + 1)
            $display("FAIL backoff: busy=%0d done=%0d done_at=%0d last_busy=%0d, want 8 1 adjacent",
                     busy_n, done_n, done_at, last_busy);
        else passed++;
        checks++;
        if (o_state !== 16'h7FFF) $display("FAIL backoff_state: state=%h, want 7fff", o_state);
        else passed++;
    endtask

    task automatic test_r_zero();
        do_reset();
        i_seed_load = 1; i_seed = 16'hACE1;
        tick();
        i_seed_load = 0; i_shift = 1;
        tick();
        i_shift = 0; i_start = 1;
        tick();
        i_start = 0;
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) $display("FAIL rzero_busy: busy=%b done=%b, want 1 0", o_busy, o_done);
        else passed++;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b1) $display("FAIL rzero_done: busy=%b done=%b, want 0 1", o_busy, o_done);
        else passed++;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL rzero_idle: busy=%b done=%b, want 0 0", o_busy, o_done);
        else passed++;
    endtask

    task automatic test_abort();
        int done_n = 0;
        do_reset();
        i_start = 1;
        tick();
        i_start = 0;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b1) $display("FAIL abort_pre: busy=%b, want 1", o_busy);
        else passed++;
        i_abort = 1;
        tick();
        i_abort = 0;
        checks++;
        if (o_busy !== 1'b0) $display("FAIL abort_busy: busy=%b, want 0", o_busy);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            if (o_done || o_busy) done_n++;
            tick();
        end
        checks++;
        if (done_n != 0) $display("FAIL abort_done: active cycles=%0d, want 0", done_n);
        else passed++;
    endtask

    task automatic test_reset_mid_count();
        int act = 0;
        do_reset();
        i_start = 1;
        tick();
        i_start = 0;
        tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_state !== 16'hFFFF) $display("FAIL rst_mid: busy=%b state=%h, want 0 ffff", o_busy, o_state);
        else passed++;
        tick();
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            if (o_done || o_busy) act++;
            tick();
        end
        checks++;
        if (act != 0) $display("FAIL rst_mid_done: active cycles=%0d, want 0", act);
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] m_s = 16'hFFFF;
        int          busy_left = 0;
        bit          m_done = 0;
        bit          idle, acc;
        logic [2:0]  r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            i_shift     = 1'($urandom_range(0, 1));
            i_seed_load = ($urandom_range(0, 9) == 0);
            i_seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            i_start     = ($urandom_range(0, 2) == 0);
            i_abort     = ($urandom_range(0, 7) == 0);
            idle = (busy_left == 0) && !m_done;
            acc  = idle && i_start && !i_abort;
            r    = m_s[2:0];
            m_s  = i_seed_load ? ((i_seed == 0) ? 16'hFFFF : i_seed) :
                   (m_s == 0) ? 16'hFFFF : (i_shift || acc) ? lfsr_step(m_s) : m_s;
            if (m_done) m_done = 0;
            else if (busy_left > 0) begin
                if (i_abort) busy_left = 0;
                else if (busy_left == 1) begin busy_left = 0; m_done = 1; end
                else busy_left--;
            end else if (acc) busy_left = int'(r) + 1;
            tick();
            checks++;
            if (o_state !== m_s || o_out !== m_s[2:0] || o_out_termo !== therm(m_s[2:0]) ||
                o_busy !== (busy_left > 0) || o_done !== m_done)
                $display("FAIL random%0d: state=%h out=%0d termo=%h busy=%b done=%b, want %h %0d %h %b %b",
                         i, o_state, o_out, o_out_termo, o_busy, o_done,
                         m_s, m_s[2:0], therm(m_s[2:0]), busy_left > 0, m_done);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_free_run();
        int zeros = 0, repeats = 0, step_err = 0, distinct = 1;
        logic [15:0] prev;
        do_reset();
        for (int i = 0; i < 65536; i++) visited[i] = 0;
        visited[16'hFFFF] = 1;
        prev = o_state;
        i_shift = 1;
        for (int i = 0; i < 65535; i++) begin
            tick();
            if (o_state !== lfsr_step(prev)) step_err++;
            if (o_state == 16'h0) zeros++;
            if (i < 65534) begin
                if (visited[o_state]) repeats++;
                else begin visited[o_state] = 1; distinct++; end
            end
            prev = o_state;
        end
        i_shift = 0;
        checks++;
        if (o_state !== 16'hFFFF) $display("FAIL freerun_end: state=%h, want ffff", o_state);
        else passed++;
        checks++;
        if (zeros != 0 || repeats != 0 || distinct != 65535 || step_err != 0)
            $display("FAIL freerun_cover: zeros=%0d repeats=%0d distinct=%0d step_err=%0d, want 0 0 65535 0",
                     zeros, repeats, distinct, step_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_shift();
        test_seed();
        test_backoff();
        test_r_zero();
        test_abort();
        test_reset_mid_count();
        test_random();
        test_free_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/rnd_backoff.md
RND_BACKOFF -- requirements
Module: rnd_backoff

Interface
REQ-001 Parameter WIDTH, default 16, LFSR length; legal range 4..32.
REQ-002 Parameter TAPS, default 16'h002D (bits 0,2,3,5), WIDTH-bit feedback tap mask.
REQ-003 Parameter OUT_W, default 3, random output width; legal range 1..5, OUT_W <= WIDTH.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 i_shift  input  1  advance LFSR one step.
REQ-007 i_seed_load  input  1  load LFSR from i_seed.
REQ-008 i_seed  input  WIDTH  seed value.
REQ-009 i_start  input  1  request random backoff interval.
REQ-010 i_abort  input  1  cancel backoff in progress.
REQ-011 o_out  output  OUT_W  current random value R = s_reg[OUT_W-1:0].
REQ-012 o_out_termo  output  2^OUT_W  thermometer code of o_out.
REQ-013 o_state  output  WIDTH  full LFSR contents.
REQ-014 o_busy  output  1  backoff counting.
REQ-015 o_done  output  1  one-cycle backoff-complete pulse.

Function
REQ-016 LFSR SHALL be Fibonacci right-shift: fb = XOR of s_reg bits selected by TAPS; next = {fb, s_reg[WIDTH-1:1]}.
REQ-017 LFSR update priority SHALL be: i_seed_load > advance (i_shift, or accepted start) > hold.
REQ-018 Seed load SHALL write i_seed, except i_seed == 0 SHALL write all ones (lock-up avoidance).
REQ-019 If s_reg is ever all zeros, next edge SHALL force all ones regardless of other inputs except i_seed_load with nonzero seed.
REQ-020 Simultaneous i_shift and accepted start SHALL advance the LFSR exactly once.
REQ-021 o_out_termo bit k SHALL be 1 iff k <= o_out (combinational from s_reg).
REQ-022 Backoff FSM states: IDLE, COUNT, DONE; counter cnt OUT_W bits.
REQ-023 IDLE: i_start=1 and i_abort=0 -> capture cnt=R (pre-advance o_out), advance LFSR, go COUNT.
REQ-024 COUNT: cnt==0 -> DONE; else cnt decrements; o_busy=1 throughout COUNT.
REQ-025 Result: o_busy high exactly R+1 cycles, immediately followed by o_done high exactly 1 cycle, then IDLE.
REQ-026 DONE SHALL return to IDLE unconditionally; i_start in DONE or COUNT SHALL be ignored (no LFSR advance).
REQ-027 i_abort in COUNT SHALL return to IDLE at next edge, cnt=0, no o_done; abort in IDLE or DONE has no effect on FSM; abort with start in IDLE: abort wins.
REQ-028 i_start with i_seed_load in IDLE: start accepted with R from pre-load value; LFSR takes seed.
REQ-029 o_busy, o_done SHALL be registered (decoded from state flops, glitch-free).

Reset
REQ-030 Reset low SHALL immediately set s_reg all ones, state IDLE, cnt 0, o_busy 0, o_done 0.
REQ-031 During reset o_out SHALL be 2^OUT_W-1 and o_out_termo all ones.
REQ-032 Reset asserted mid-COUNT SHALL abandon backoff with no o_done pulse after release.

Verification (defaults WIDTH=16, OUT_W=3)
REQ-033 Reset, 3 cycles i_shift -> o_state 0xFFFF, 0x7FFF, 0x3FFF, 0x1FFF; o_out 7 each.
REQ-034 Seed 0x0000 -> o_state 0xFFFF; seed 0xACE1 then one shift -> 0x5670, o_out 0, o_out_termo 8'h01.
REQ-035 After reset, i_start one cycle -> o_busy 8 cycles, o_done 1 cycle, o_state 0x7FFF, second i_start during busy ignored.
REQ-036 Seed 0xACE1, shift (R=0), i_start -> o_busy 1 cycle then o_done 1 cycle.
REQ-037 i_start with R=7, i_abort on 3rd busy cycle -> o_busy low next edge, o_done never asserted; Reset mid-COUNT likewise.
REQ-038 Free-run 65535 shifts from 0xFFFF -> returns to 0xFFFF, never all zeros, every nonzero state visited once.
